// File: rtl/forward_pipe_if.sv
// Issue/forwarding bus between a decode stage and the forward_pipe hazard unit.
// The slave side is the hazard unit; the master side is decode plus the datapath.
interface forward_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int STAGES = 2,
  parameter int CW     = 16
);
  logic                      issue_valid;
  logic [AW-1:0]             issue_rd;
  logic [AW-1:0]             rs;
  logic [AW-1:0]             rt;
  logic                      use_rs;
  logic                      use_rt;
  logic                      issue_is_load;
  logic [WIDTH-1:0]          rf_v1;
  logic [WIDTH-1:0]          rf_v2;
  logic [STAGES*WIDTH-1:0]   stage_out;
  logic                      flush;
  logic [WIDTH-1:0]          v1;
  logic [WIDTH-1:0]          v2;
  logic                      stall;
  logic                      issue_accept;
  logic                      wb_valid;
  logic [AW-1:0]             wb_rd;
  logic [CW-1:0]             stall_count;

  modport slave (
    input  issue_valid, issue_rd, rs, rt, use_rs, use_rt, issue_is_load,
           rf_v1, rf_v2, stage_out, flush,
    output v1, v2, stall, issue_accept, wb_valid, wb_rd, stall_count
  );

  modport master (
    output issue_valid, issue_rd, rs, rt, use_rs, use_rt, issue_is_load,
           rf_v1, rf_v2, stage_out, flush,
    input  v1, v2, stall, issue_accept, wb_valid, wb_rd, stall_count
  );
endinterface

// File: rtl/forward_pipe.sv
// Operand forwarding and load-use stall unit: tracks {valid, rd, is_load} per
// post-decode stage and picks the youngest producer for each source operand.

// Per-stage comparator: does this stage's entry produce rs / rt, and is it ready.
module fp_stage_match #(
  parameter int AW         = 5,
  parameter int IDX        = 1,
  parameter int LOAD_READY = 2
) (
  input  logic          vld,
  input  logic [AW-1:0] rd,
  input  logic          is_load,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          hit_rs,
  output logic          hit_rt,
  output logic          ready
);
  logic live;

  // rd = 0 is "no destination", so it can never satisfy a source
  assign live   = vld && (rd != '0);
  assign hit_rs = live && (rd == rs);
  assign hit_rt = live && (rd == rt);
  assign ready  = !(is_load && (IDX < LOAD_READY));
endmodule

module forward_pipe #(
  parameter int WIDTH      = 32,
  parameter int AW         = 5,
  parameter int STAGES     = 2,
  parameter int LOAD_READY = 2,
  parameter int CW         = 16
) (
  input  logic           clk,
  input  logic           reset,
  forward_pipe_if.slave  bus
);
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    logic          is_load;
  } entry_t;

  entry_t            pipe [1:STAGES];
  logic [STAGES:1]   hit_rs;
  logic [STAGES:1]   hit_rt;
  logic [STAGES:1]   rdy;
  logic              m_rs, r_rs, m_rt, r_rt;
  logic [WIDTH-1:0]  f_rs, f_rt;
  logic              stall;
  logic              accept;
  logic [CW-1:0]     cnt;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    fp_stage_match #(.AW(AW), .IDX(k), .LOAD_READY(LOAD_READY)) u_match (
      .vld     (pipe[k].vld),
      .rd      (pipe[k].rd),
      .is_load (pipe[k].is_load),
      .rs      (bus.rs),
      .rt      (bus.rt),
      .hit_rs  (hit_rs[k]),
      .hit_rt  (hit_rt[k]),
      .ready   (rdy[k])
    );
  end

  // Scan oldest to youngest so the lowest-numbered hit overrides the rest
  always_comb begin
    m_rs = 1'b0;
    r_rs = 1'b0;
    f_rs = '0;
    m_rt = 1'b0;
    r_rt = 1'b0;
    f_rt = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (hit_rs[k]) begin
        m_rs = 1'b1;
        r_rs = rdy[k];
        f_rs = bus.stage_out[(k-1)*WIDTH +: WIDTH];
      end
      if (hit_rt[k]) begin
        m_rt = 1'b1;
        r_rt = rdy[k];
        f_rt = bus.stage_out[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign stall  = bus.issue_valid &&
                  ((bus.use_rs && m_rs && !r_rs) || (bus.use_rt && m_rt && !r_rt));
  assign accept = bus.issue_valid && !stall && !bus.flush;

  assign bus.v1           = (m_rs && r_rs) ? f_rs : bus.rf_v1;
  assign bus.v2           = (m_rt && r_rt) ? f_rt : bus.rf_v2;
  assign bus.stall        = stall;
  assign bus.issue_accept = accept;
  assign bus.wb_valid     = pipe[STAGES].vld;
  assign bus.wb_rd        = pipe[STAGES].rd;
  assign bus.stall_count  = cnt;

  // Entries advance every cycle; a flush turns the stage-1 entry into a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) pipe[k] <= '0;
    end else begin
      pipe[1] <= accept ? entry_t'({1'b1, bus.issue_rd, bus.issue_is_load}) : '0;
      for (int k = 2; k <= STAGES; k++)
        pipe[k] <= (k == 2 && bus.flush) ? '0 : pipe[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (stall && !bus.flush && cnt != '1)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_forward_pipe.sv
// Bench for forward_pipe: retire order via a writeback scoreboard, forwarding
// and stall behaviour via per-scenario inline checks on two parameterisations.
module tb_forward_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  forward_pipe_if #(.WIDTH(32), .AW(5), .STAGES(2), .CW(16)) b();
  forward_pipe_if #(.WIDTH(32), .AW(5), .STAGES(4), .CW(2))  b4();

  forward_pipe #(.WIDTH(32), .AW(5), .STAGES(2), .LOAD_READY(2), .CW(16)) dut (
    .clk(clk), .reset(reset), .bus(b.slave));
  forward_pipe #(.WIDTH(32), .AW(5), .STAGES(4), .LOAD_READY(3), .CW(2)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave));

  int n_chk = 0;
  int n_pass = 0;
  int exp_sc = 0;
  logic [4:0] exp_q[$];

  // Scoreboard: every retirement must match the oldest accepted rd
  always @(negedge clk) begin : mon
    logic [4:0] e;
    if (!reset && b.wb_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_order: got retire rd=%0d, want no retire", b.wb_rd);
      end else begin
        e = exp_q.pop_front();
        if (b.wb_rd !== e) $display("FAIL wb_order: got rd=%0d want %0d", b.wb_rd, e);
        else n_pass++;
      end
    end
  end

  task automatic idle();
    b.issue_valid = 0; b.issue_rd = 0; b.rs = 0; b.rt = 0;
    b.use_rs = 0; b.use_rt = 0; b.issue_is_load = 0; b.flush = 0;
    b.rf_v1 = 32'hF1F1_0001; b.rf_v2 = 32'hF2F2_0002;
    b.stage_out = 64'hBBBB_0002_AAAA_0001;
    b4.issue_valid = 0; b4.issue_rd = 0; b4.rs = 0; b4.rt = 0;
    b4.use_rs = 0; b4.use_rt = 0; b4.issue_is_load = 0; b4.flush = 0;
    b4.rf_v1 = 32'hE1E1_0001; b4.rf_v2 = 32'hE2E2_0002;
    b4.stage_out = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic ld, input logic [4:0] rs,
                       input logic urs, input logic [4:0] rt, input logic urt);
    b.issue_valid = 1; b.issue_rd = rd; b.issue_is_load = ld;
    b.rs = rs; b.use_rs = urs; b.rt = rt; b.use_rt = urt;
  endtask

  task automatic test_reset();
    idle();
    drive(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1);
    tick(); #1;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %0b want 0", b.wb_valid); else n_pass++;
    n_chk++; if (b.stall_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", b.stall_count); else n_pass++;
    n_chk++; if (b.v1 !== 32'hF1F1_0001) $display("FAIL rst_v1: got %h want f1f10001", b.v1); else n_pass++;
    n_chk++; if (b.v2 !== 32'hF2F2_0002) $display("FAIL rst_v2: got %h want f2f20002", b.v2); else n_pass++;
    idle();
    reset = 0;
    tick();
  endtask

  task automatic test_alu_forward();
    drive(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    n_chk++; if (b.issue_accept !== 1'b1) $display("FAIL alu_accept: got %0b want 1", b.issue_accept); else n_pass++;
    exp_q.push_back(5'd3);
    tick();
    drive(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    b.stage_out[31:0] = 32'h0000_1234;
    #1;
    n_chk++; if (b.v1 !== 32'h0000_1234) $display("FAIL alu_v1: got %h want 00001234", b.v1); else n_pass++;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL alu_stall: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.v2 !== 32'hF2F2_0002) $display("FAIL alu_v2: got %h want f2f20002", b.v2); else n_pass++;
    exp_q.push_back(5'd0);
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int k = 1; k <= 4; k++) begin
      drive(5'(k), 1'b0, 5'(k - 1), 1'b1, 5'd0, 1'b0);
      b.stage_out[31:0] = 32'h100 + 32'(k);
      #1;
      want = (k == 1) ? 32'hF1F1_0001 : 32'h100 + 32'(k);
      n_chk++; if (b.v1 !== want) $display("FAIL b2b_v1[%0d]: got %h want %h", k, b.v1, want); else n_pass++;
      n_chk++; if (b.issue_accept !== 1'b1) $display("FAIL b2b_accept[%0d]: got %0b want 1", k, b.issue_accept); else n_pass++;
      exp_q.push_back(5'(k));
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_load_use();
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd5);
    tick();
    drive(5'd6, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    n_chk++; if (b.stall !== 1'b1) $display("FAIL lu_stall1: got %0b want 1", b.stall); else n_pass++;
    n_chk++; if (b.issue_accept !== 1'b0) $display("FAIL lu_accept1: got %0b want 0", b.issue_accept); else n_pass++;
    n_chk++; if (b.v2 !== 32'hF2F2_0002) $display("FAIL lu_v2_early: got %h want f2f20002", b.v2); else n_pass++;
    exp_sc++;
    tick();
    n_chk++; if (b.stall !== 1'b0) $display("FAIL lu_stall2: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.issue_accept !== 1'b1) $display("FAIL lu_accept2: got %0b want 1", b.issue_accept); else n_pass++;
    n_chk++; if (b.v2 !== 32'hBBBB_0002) $display("FAIL lu_v2_fwd: got %h want bbbb0002", b.v2); else n_pass++;
    exp_q.push_back(5'd6);
    tick();
    idle();
    n_chk++; if (b.stall_count !== 16'(exp_sc)) $display("FAIL lu_count: got %0d want %0d", b.stall_count, exp_sc); else n_pass++;
    tick(); tick();
  endtask

  task automatic test_youngest();
    drive(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd7);
    tick();
    exp_q.push_back(5'd7);
    tick();
    drive(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0);
    b.stage_out = 64'h0000_000B_0000_000A;
    #1;
    n_chk++; if (b.v1 !== 32'hA) $display("FAIL young_v1: got %h want 0000000a", b.v1); else n_pass++;
    n_chk++; if (b.v2 !== 32'hA) $display("FAIL young_v2: got %h want 0000000a", b.v2); else n_pass++;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL young_stall: got %0b want 0", b.stall); else n_pass++;
    exp_q.push_back(5'd0);
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_reg0();
    drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd0);
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL r0_stall: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.v1 !== 32'hF1F1_0001) $display("FAIL r0_v1: got %h want f1f10001", b.v1); else n_pass++;
    exp_q.push_back(5'd0);
    tick();
    drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd4);
    tick();
    drive(5'd0, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0);
    #1;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL unused_stall: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.issue_accept !== 1'b1) $display("FAIL unused_accept: got %0b want 1", b.issue_accept); else n_pass++;
    n_chk++; if (b.v1 !== 32'hF1F1_0001) $display("FAIL unused_v1: got %h want f1f10001", b.v1); else n_pass++;
    exp_q.push_back(5'd0);
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_flush();
    drive(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd2);
    tick();
    drive(5'd11, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0);
    b.flush = 1;
    #1;
    n_chk++; if (b.stall !== 1'b1) $display("FAIL fl_stall: got %0b want 1", b.stall); else n_pass++;
    n_chk++; if (b.issue_accept !== 1'b0) $display("FAIL fl_accept: got %0b want 0", b.issue_accept); else n_pass++;
    void'(exp_q.pop_back());
    tick();
    b.flush = 0;
    #1;
    n_chk++; if (b.stall_count !== 16'(exp_sc)) $display("FAIL fl_count: got %0d want %0d", b.stall_count, exp_sc); else n_pass++;
    n_chk++; if (b.wb_valid !== 1'b0) $display("FAIL fl_stage2: got %0b want 0", b.wb_valid); else n_pass++;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL fl_restart: got %0b want 0", b.stall); else n_pass++;
    exp_q.push_back(5'd11);
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive(5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd13);
    tick();
    drive(5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd14);
    tick();
    drive(5'd15, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
    #1;
    n_chk++; if (b.stall !== 1'b1) $display("FAIL mid_prestall: got %0b want 1", b.stall); else n_pass++;
    reset = 1;
    exp_q.delete();
    exp_sc = 0;
    #1;
    n_chk++; if (b.wb_valid !== 1'b0) $display("FAIL mid_wb_valid: got %0b want 0", b.wb_valid); else n_pass++;
    n_chk++; if (b.stall !== 1'b0) $display("FAIL mid_stall: got %0b want 0", b.stall); else n_pass++;
    n_chk++; if (b.stall_count !== 16'd0) $display("FAIL mid_count: got %0d want 0", b.stall_count); else n_pass++;
    idle();
    tick();
    reset = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_sweep();
    b4.issue_valid = 1; b4.issue_rd = 5'd9; b4.issue_is_load = 1;
    #1;
    n_chk++; if (b4.issue_accept !== 1'b1) $display("FAIL sw_accept: got %0b want 1", b4.issue_accept); else n_pass++;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      b4.issue_valid = 1; b4.issue_rd = 5'd10; b4.issue_is_load = 0;
      b4.rs = 5'd9; b4.use_rs = 1;
      for (int s = 0; s < 2; s++) begin
        #1;
        n_chk++; if (b4.stall !== 1'b1) $display("FAIL sw_stall[%0d.%0d]: got %0b want 1", rep, s, b4.stall); else n_pass++;
        tick();
      end
      #1;
      n_chk++; if (b4.stall !== 1'b0) $display("FAIL sw_release[%0d]: got %0b want 0", rep, b4.stall); else n_pass++;
      n_chk++; if (b4.v1 !== 32'h3333) $display("FAIL sw_v1[%0d]: got %h want 00003333", rep, b4.v1); else n_pass++;
      n_chk++; if (b4.stall_count !== (rep == 0 ? 2'd2 : 2'd3))
        $display("FAIL sw_count[%0d]: got %0d want %0d", rep, b4.stall_count, rep == 0 ? 2 : 3);
      else n_pass++;
      tick();
      b4.issue_valid = 1; b4.issue_rd = 5'd9; b4.issue_is_load = 1;
      b4.rs = 5'd0; b4.use_rs = 0;
      tick();
    end
    idle();
    #1;
    n_chk++; if (b4.stall_count !== 2'd3) $display("FAIL sw_saturate: got %0d want 3", b4.stall_count); else n_pass++;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_reg0();
    test_flush();
    test_reset_mid();
    test_sweep();
    tick(); tick();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL wb_drain: got %0d pending retirements want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
